// File: rtl/sram_req_ctrl_pkg.sv
// rtl/sram_req_ctrl_pkg.sv - shared types and default geometry for sram_req_ctrl
// Holds the controller state enum and the default WORDS/BITS/AW values.
package sram_req_ctrl_pkg;

    localparam int WORDS_DEF = 128;
    localparam int BITS_DEF  = 32;
    localparam int AW_DEF    = 7;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/resp_fifo2.sv
// rtl/resp_fifo2.sv - two-entry response FIFO for read data
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_din    write an entry (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   o_dout           head entry (0 after reset)
//   o_full, o_empty  occupancy flags
module resp_fifo2 #(
    parameter int BITS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic [BITS-1:0] i_din,
    input  logic            i_pop,
    output logic [BITS-1:0] o_dout,
    output logic            o_full,
    output logic            o_empty
);

    logic [BITS-1:0] r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - request/response front end for a single-port SRAM macro
// Ports:
//   CLK, RST_N                         clock, asynchronous active-low reset
//   req_valid/req_ready/req_write      request handshake and direction
//   req_addr, req_wdata                request address and write data
//   resp_valid/resp_ready/resp_rdata   read response stream (2-deep buffer)
//   init_done                          high once the post-reset clear is finished
//   sram_CEB, sram_WEB                 macro chip/write enable, active-low
//   sram_A, sram_D, sram_Q             macro address, write data, read data
module sram_req_ctrl
    import sram_req_ctrl_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int BITS  = BITS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [BITS-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [BITS-1:0] resp_rdata,
    output logic            init_done,
    output logic            sram_CEB,
    output logic            sram_WEB,
    output logic [AW-1:0]   sram_A,
    output logic [BITS-1:0] sram_D,
    input  logic [BITS-1:0] sram_Q
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic          r_rd_pend;
    logic          w_init_we;
    logic          w_accept;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_fifo_empty_n;
    logic [1:0]    w_occ;
    logic [2:0]    w_outstanding;

    // Occupancy from the flags: full=2, not empty=1, else 0.
    assign w_fifo_empty_n = !w_fifo_empty;
    assign w_occ          = {w_fifo_full, w_fifo_empty_n && !w_fifo_full};
    // A pop this cycle is deliberately not credited; it frees space next cycle.
    assign w_outstanding  = {1'b0, w_occ} + {2'b00, r_rd_pend};

    // The clear writes are gated by RST_N so the macro stays idle during reset.
    assign w_init_we  = (r_state == ST_INIT) && RST_N;
    assign init_done  = (r_state == ST_RUN);
    assign req_ready  = init_done && (req_write || (w_outstanding < 3'd2));
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = w_fifo_empty_n;

    always_comb begin
        w_state_nxt = r_state;
        sram_CEB    = 1'b1;
        sram_WEB    = 1'b1;
        sram_A      = req_addr;
        sram_D      = req_wdata;
        case (r_state)
            ST_INIT: begin
                if (w_init_we) begin
                    sram_CEB = 1'b0;
                    sram_WEB = 1'b0;
                    sram_A   = r_init_cnt;
                    sram_D   = '0;
                end
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    sram_CEB = 1'b0;
                    sram_WEB = !req_write;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_rd_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            // Macro output is valid the cycle after a read is accepted.
            r_rd_pend <= w_accept && !req_write;
        end
    end

    resp_fifo2 #(
        .BITS(BITS)
    ) u_resp_fifo2 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (r_rd_pend),
        .i_din   (sram_Q),
        .i_pop   (resp_valid && resp_ready),
        .o_dout  (resp_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - scoreboard bench for sram_req_ctrl with a behavioural SRAM
module tb_sram_req_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        init_done;
    logic        sram_CEB;
    logic        sram_WEB;
    logic [6:0]  sram_A;
    logic [31:0] sram_D;
    logic [31:0] sram_Q = 32'hA5A5_5A5A;

    always #5 CLK = ~CLK;

    sram_req_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_CEB   (sram_CEB),
        .sram_WEB   (sram_WEB),
        .sram_A     (sram_A),
        .sram_D     (sram_D),
        .sram_Q     (sram_Q)
    );

    // Single-port synchronous SRAM macro, seeded with garbage.
    logic [31:0] sram_mem [128];
    initial begin
        for (int i = 0; i < 128; i++) sram_mem[i] = $urandom;
    end
    always @(posedge CLK) begin
        if (!sram_CEB) begin
            if (!sram_WEB) sram_mem[sram_A] = sram_D;
            else           sram_Q <= sram_mem[sram_A];
        end
    end

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_rd_acc = 0;
    int          n_popped = 0;
    logic [31:0] ref_mem [128];
    logic [31:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every presented response must match the oldest expected one.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (RST_N && resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
                end else begin
                    chk("resp_rdata", resp_rdata, exp_q[0]);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        n_popped++;
                    end
                end
            end
        end
    end

    // One request cycle; readiness expected from outstanding reads (accepted, not yet popped).
    task automatic cyc(input logic v, input logic w, input logic [6:0] a,
                       input logic [31:0] d, input logic rr, output logic acc);
        logic exp_rdy;
        @(negedge CLK);
        req_valid  = v;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = rr;
        #1;
        if (v) begin
            exp_rdy = w ? 1'b1 : ((n_rd_acc - n_popped) < 2);
            chk(w ? "req_ready_wr" : "req_ready_rd", {31'b0, req_ready}, {31'b0, exp_rdy});
        end
        acc = v && req_ready;
        chk("sram_CEB", {31'b0, sram_CEB}, {31'b0, !acc});
        if (acc) begin
            chk("sram_WEB", {31'b0, sram_WEB}, {31'b0, !w});
            chk("sram_A", {25'b0, sram_A}, {25'b0, a});
            chk("sram_D", sram_D, d);
            if (w) begin
                ref_mem[a] = d;
            end else begin
                exp_q.push_back(ref_mem[a]);
                n_rd_acc++;
            end
        end
    endtask

    task automatic reset_and_init();
        @(negedge CLK);
        RST_N      = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        resp_ready = 1'b0;
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_sram_CEB", {31'b0, sram_CEB}, 32'd1);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        exp_q.delete();
        n_rd_acc = 0;
        n_popped = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 128; i++) begin
            if (i != 0) @(negedge CLK);
            req_write = 1'($urandom);
            req_addr  = 7'($urandom);
            req_wdata = $urandom;
            #1;
            chk("init_CEB", {31'b0, sram_CEB}, 32'd0);
            chk("init_WEB", {31'b0, sram_WEB}, 32'd0);
            chk("init_A", {25'b0, sram_A}, i);
            chk("init_D", sram_D, 32'd0);
            chk("init_req_ready", {31'b0, req_ready}, 32'd0);
            chk("init_done_low", {31'b0, init_done}, 32'd0);
        end
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        chk("init_done_high", {31'b0, init_done}, 32'd1);
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'd0;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, acc);
        end
        cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, acc);
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic acc;
        logic got;
        reset_and_init();

        // Unwritten location reads back as cleared.
        cyc(1'b1, 1'b0, 7'd127, 32'd0, 1'b1, acc);
        chk("rd127_acc", {31'b0, acc}, 32'd1);
        drain();

        // Write then read same address, latency check.
        cyc(1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1, acc);
        cyc(1'b1, 1'b0, 7'd5, 32'd0, 1'b1, acc);
        cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, acc);
        chk("lat_t2_valid", {31'b0, resp_valid}, 32'd0);
        cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, acc);
        chk("lat_t3_valid", {31'b0, resp_valid}, 32'd1);
        chk("lat_t3_data", resp_rdata, 32'hDEADBEEF);
        drain();

        // Back-pressure: two reads buffered, third stalls until space frees.
        cyc(1'b1, 1'b1, 7'd1, 32'h11, 1'b1, acc);
        cyc(1'b1, 1'b1, 7'd2, 32'h22, 1'b1, acc);
        cyc(1'b1, 1'b1, 7'd3, 32'h33, 1'b1, acc);
        cyc(1'b1, 1'b0, 7'd1, 32'd0, 1'b0, acc);
        cyc(1'b1, 1'b0, 7'd2, 32'd0, 1'b0, acc);
        repeat (3) cyc(1'b1, 1'b0, 7'd3, 32'd0, 1'b0, acc);
        chk("bp_third_blocked", {31'b0, req_ready}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc(1'b1, 1'b0, 7'd3, 32'd0, 1'b1, acc);
            got = acc;
        end
        chk("bp_third_accept", {31'b0, got}, 32'd1);
        drain();

        // Full-rate write stream, then a read stream with resp_ready held.
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b1, 7'($urandom_range(0, 15)), $urandom, 1'b1, acc);
            chk("wr_stream_acc", {31'b0, acc}, 32'd1);
        end
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, 7'($urandom_range(0, 15)), 32'd0, 1'b1, acc);
        end
        drain();

        // Randomised mix with narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 7'($urandom_range(0, 7)),
                $urandom, 1'($urandom_range(0, 2) != 0), acc);
        end
        drain();

        // Reset with one response buffered and one read in flight.
        cyc(1'b1, 1'b0, 7'd2, 32'd0, 1'b0, acc);
        cyc(1'b1, 1'b0, 7'd3, 32'd0, 1'b0, acc);
        reset_and_init();
        repeat (4) cyc(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, acc);
        cyc(1'b1, 1'b1, 7'd9, 32'hCAFE_F00D, 1'b1, acc);
        cyc(1'b1, 1'b0, 7'd9, 32'd0, 1'b1, acc);
        cyc(1'b1, 1'b0, 7'd3, 32'd0, 1'b1, acc);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
